// File: rtl/prog_loader.sv
// prog_loader: loads a byte stream (clk, rst low-active, start/len, byte_in/valid/ready) into imem (addr/data/we), then runs the core via cpu_rst and flags halt on done; busy/err report load status
module prog_loader #(
  parameter int MEM_DEPTH   = 1000,
  parameter int HALT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] len,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_data,
  output logic        imem_we,
  output logic        cpu_rst,
  input  logic [15:0] cpu_pc,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, RX_HI, RX_LO, WRITE, RUN, HALTED} state_t;
  state_t state, state_nx;
  logic [15:0] len_q, word_cnt, prev_pc, halt_cnt;
  logic [7:0] hi, lo;
  logic legal, can_start, load_ok, xfer, pc_same, halt_hit;
  assign legal     = len != 16'd0 && len <= 16'(MEM_DEPTH);
  assign can_start = state == IDLE || state == RUN || state == HALTED;
  assign load_ok   = start && legal && can_start;
  assign xfer      = byte_valid && byte_ready;
  assign pc_same   = cpu_pc == prev_pc;
  assign halt_hit  = pc_same && halt_cnt == 16'(HALT_CYCLES - 2);
  assign imem_addr = word_cnt;
  assign imem_data = {hi, lo};
  always_comb begin
    byte_ready = state == RX_HI || state == RX_LO;
    imem_we    = state == WRITE;
    busy       = byte_ready || imem_we;
    cpu_rst    = state == RUN || state == HALTED;
    done       = state == HALTED;
    state_nx   = load_ok                   ? RX_HI :
                 (state == RX_HI && xfer)  ? RX_LO :
                 (state == RX_LO && xfer)  ? WRITE :
                 state == WRITE            ? (word_cnt == len_q - 16'd1 ? RUN : RX_HI) :
                 (state == RUN && halt_hit) ? HALTED : state;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      len_q    <= '0;
      word_cnt <= '0;
      prev_pc  <= '0;
      halt_cnt <= '0;
      hi       <= '0;
      lo       <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nx;
      if (start && can_start) err <= !legal;
      if (load_ok) begin
        len_q    <= len;
        word_cnt <= '0;
      end else if (state == WRITE && state_nx == RX_HI) begin
        word_cnt <= word_cnt + 16'd1;
      end
      if (state == RX_HI && xfer) hi <= byte_in;
      if (state == RX_LO && xfer) lo <= byte_in;
      // outside RUN the pc history is parked at 0 so the first RUN cycle compares against 0
      prev_pc  <= state == RUN ? cpu_pc : 16'd0;
      halt_cnt <= state == RUN && pc_same ? halt_cnt + 16'd1 : 16'd0;
    end
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot/run controller for the 16-bit processor core.
- Holds the core in reset and accepts a byte stream over a valid/ready handshake. Assembles the bytes into 16-bit words, high byte first, and writes them into instruction memory starting at address 0.
- After loading, releases the core and monitors its program address to detect a halt.
- Sits between the host/debug byte link, the instruction memory write port and the core's rst input.

Parameters:
- MEM_DEPTH, 1000, number of instruction words; legal load lengths are 1..MEM_DEPTH.
- HALT_CYCLES, 4, consecutive cycles with an unchanged cpu_pc that declare the core halted; minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-low.
- start  input  1  single-cycle pulse that begins a load.
- len  input  16  number of words to load; sampled only on an accepted start.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte this cycle.
- imem_addr  output  16  instruction memory write address.
- imem_data  output  16  instruction memory write data.
- imem_we  output  1  instruction memory write enable.
- cpu_rst  output  1  active-low reset to the core; 0 holds the core in reset.
- cpu_pc  input  16  the core's program address.
- busy  output  1  a load is in progress.
- done  output  1  the core has halted after a load.
- err  output  1  the last start request had an illegal len.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; word counter=0; halt counter=0.
  - cpu_rst=0, imem_we=0, imem_addr=0, imem_data=0, byte_ready=0, busy=0, done=0, err=0.
  - The core is held in reset until a successful load completes.
- States: IDLE, RX_HI, RX_LO, WRITE, RUN, HALTED.
- Byte transfer occurs when byte_valid=1 and byte_ready=1 at the same clk edge.
  - byte_ready=1 only in RX_HI and RX_LO; it is decoded from the state register.
  - byte_in is ignored whenever no transfer occurs.
- IDLE:
  - start=1 with len==0 or len>MEM_DEPTH: set err=1 and stay in IDLE.
  - start=1 with a legal len: latch len, clear err, done and the word counter, drive cpu_rst=0, go to RX_HI.
- RX_HI: on transfer, capture the high byte and go to RX_LO.
- RX_LO: on transfer, capture the low byte and go to WRITE.
- WRITE (exactly one cycle):
  - imem_we=1, imem_addr=word counter, imem_data={hi,lo}.
  - If word counter==len-1: go to RUN with cpu_rst=1 from the first RUN cycle.
  - Otherwise: increment the word counter and go to RX_HI.
  - imem_we=0 in every other state.
  - Minimum cost is 3 cycles per word.
- busy=1 in RX_HI, RX_LO and WRITE; 0 otherwise.
- RUN:
  - Each cycle, compare cpu_pc with a registered copy of its previous value.
  - Equal: increment the halt counter. Different: clear the halt counter.
  - When the halt counter reaches HALT_CYCLES-1: go to HALTED and set done=1.
  - The first RUN cycle compares against the pc captured at entry, which is 0.
- HALTED: cpu_rst stays 1 and done stays 1.
- A branch-to-self loop is indistinguishable from a halt and is reported as done.
- start in RUN or HALTED (abort/reload):
  - Legal len: cpu_rst=0 on the next cycle, done=0, go to RX_HI.
  - Illegal len: err=1 and the state is unchanged.
- start during RX_HI, RX_LO or WRITE is ignored; len is not resampled and err is unchanged.
- Stall behaviour: byte_valid may stay low indefinitely in RX_*; no timeout.
- Word counter width is 16 bits. It never exceeds len-1, so no wrap is possible.
- rst=0 mid-load or mid-run: returns immediately to the reset state, including cpu_rst=0. Memory contents already written are not cleared.

Test Plan:
- Basic load: start with len=3; bytes 12 34 56 78 9A BC; all byte_valid=1 -> three imem_we pulses writing addr0=1234, addr1=5678, addr2=9ABC; cpu_rst rises the cycle after the third write; busy is 1 throughout the load.
- Illegal len: start with len=0, then start with len=1001 -> err=1 both times, state IDLE, no imem_we, cpu_rst=0. Then start with len=1 -> err clears.
- Backpressure and gaps: byte_valid toggled 1,0,0,1 with byte_ready observed -> only accepted bytes are captured; a single write of the correct word; byte_in changing during valid=0 has no effect.
- Halt detect with HALT_CYCLES=4: after release, drive cpu_pc 0,1,2,5,5,5,5 -> done=1 exactly on the cycle after the fourth 5. Drive 5,5,6 -> the counter resets and done stays 0.
- Reload: in HALTED, start with len=2 -> cpu_rst=0 and done=0 on the next cycle; new words are written at addr0 and addr1; the core is released again.
- Mid-load reset: rst=0 after one word is written -> all outputs return to reset values. start ignored during RX_LO -> no state change.
